// File: rtl/iob_prio_dec_if.sv
`timescale 1ns/1ps
// Stream bundle for iob_prio_dec: index in (valid/ready), one-hot + error out (valid/ready).
interface iob_prio_dec_if #(parameter int W = 8);
    localparam int EW = $clog2(W);

    logic [EW-1:0] encoded_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  decoded_o;
    logic          err_o;
    logic          valid_o;
    logic          ready_i;

    modport master (
        output encoded_i, valid_i, ready_i,
        input  ready_o, decoded_o, err_o, valid_o
    );

    modport slave (
        input  encoded_i, valid_i, ready_i,
        output ready_o, decoded_o, err_o, valid_o
    );
endinterface

// File: rtl/iob_prio_dec.sv
`timescale 1ns/1ps
// Streaming binary-to-one-hot decoder with a 2-entry skid buffer and a sticky
// accumulation mask of every one-hot delivered downstream.
module iob_prio_dec #(
    parameter int W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cke_i,
    iob_prio_dec_if.slave bus,
    input  logic          acc_clr_i,
    output logic [W-1:0]  acc_o,
    output logic          acc_full_o
);
    localparam int EW = $clog2(W);

    // Returns {err, one-hot}; indices past W-1 give an all-zero vector with err set.
    function automatic logic [W:0] decode(input logic [EW-1:0] idx);
        logic [W-1:0] vec;
        vec = '0;
        for (int i = 0; i < W; i++) begin
            vec[i] = (int'(idx) == i);
        end
        return {(int'(idx) >= W), vec};
    endfunction

    logic [W-1:0] dec_p0;
    logic         err_p0;
    logic         vld_p1;
    logic [W-1:0] dec_p1;
    logic         err_p1;
    logic         skid_vld_p1;
    logic [W-1:0] skid_dec_p1;
    logic         skid_err_p1;
    logic         in_xfer;
    logic         out_xfer;
    logic [W-1:0] acc_nxt;

    // ---- stage p0: combinational decode of the incoming index ----
    assign {err_p0, dec_p0} = decode(bus.encoded_i);

    assign in_xfer  = bus.valid_i && !skid_vld_p1;
    assign out_xfer = vld_p1 && bus.ready_i;

    assign bus.ready_o   = !skid_vld_p1;
    assign bus.valid_o   = vld_p1;
    assign bus.decoded_o = dec_p1;
    assign bus.err_o     = err_p1;

    // Clear takes effect before the delivered bit is merged in.
    always_comb begin
        acc_nxt = acc_clr_i ? '0 : acc_o;
        if (out_xfer) begin
            acc_nxt = acc_nxt | dec_p1;
        end
    end

    // ---- stage p1: main register, skid register, accumulator ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1      <= 1'b0;
            dec_p1      <= '0;
            err_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            acc_o       <= '0;
            acc_full_o  <= 1'b0;
        end else if (cke_i) begin
            acc_o      <= acc_nxt;
            acc_full_o <= &acc_nxt;
            if (skid_vld_p1) begin
                if (out_xfer) begin
                    vld_p1      <= 1'b1;
                    dec_p1      <= skid_dec_p1;
                    err_p1      <= skid_err_p1;
                    skid_vld_p1 <= 1'b0;
                end
            end else if (!vld_p1 || out_xfer) begin
                vld_p1 <= in_xfer;
                if (in_xfer) begin
                    dec_p1 <= dec_p0;
                    err_p1 <= err_p0;
                end
            end else if (in_xfer) begin
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    // Skid payload is only meaningful while skid_vld_p1 is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (cke_i && in_xfer && vld_p1 && !out_xfer) begin
            skid_dec_p1 <= dec_p0;
            skid_err_p1 <= err_p0;
        end
    end
endmodule

// File: doc/iob_prio_dec.md
Name: iob_prio_dec

Overview:
- Streaming binary-to-one-hot decoder. It is the inverse of the cache's priority encoder.
- Accepts way/line indices on a valid/ready input and emits registered one-hot vectors through a 2-entry skid buffer.
- Keeps a sticky accumulation mask of all delivered one-hots, used for way-select and replacement/valid-bit bookkeeping inside iob_cache.

Parameters:
- W, 8, one-hot output width; legal range W >= 2, power of 2 not required.
- EW, $clog2(W), encoded index width; derived, not overridable by instantiation.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- cke_i  input  1  clock enable; when 0 every register holds
- encoded_i  input  EW  index to decode
- valid_i  input  1  encoded_i valid
- ready_o  output  1  decoder can accept
- decoded_o  output  W  one-hot result
- err_o  output  1  decoded_o belongs to an out-of-range index
- valid_o  output  1  decoded_o/err_o valid
- ready_i  input  1  downstream accepts
- acc_clr_i  input  1  clear accumulation mask
- acc_o  output  W  OR of all one-hots delivered since last clear
- acc_full_o  output  1  acc_o is all ones

Behaviour:
- One clock, clk_i. All state updates on the rising edge only when cke_i=1.
- rst_i is synchronous, active-high, and takes effect regardless of cke_i.
- Reset values: ready_o=1, valid_o=0, decoded_o=0, err_o=0, acc_o=0, acc_full_o=0. Both buffer entries are emptied.
- Decode function, with idx = encoded_i:
  - if idx < W: bit idx = 1, all others 0, err=0.
  - if idx >= W (only possible when W is not a power of 2): vector all zeros, err=1.
  - err travels with its data through the buffer.
- Input transfer: valid_i && ready_o. Output transfer: valid_o && ready_i.
- Storage: main register (drives decoded_o/err_o/valid_o) and skid register.
- ready_o is registered and equals !skid_valid. It never depends combinationally on ready_i.
- Latency: a transfer accepted in cycle N appears on decoded_o in cycle N+1 when the main register is empty or draining.
- Per-edge rules (cke_i=1):
  - main empty, input transfer: data goes to main.
  - main full, output transfer, input transfer: input data goes to main (skid empty case).
  - main full, no output transfer, input transfer: input data goes to skid; ready_o drops next cycle.
  - skid full, output transfer: skid moves to main; skid empties; ready_o rises next cycle.
  - main full, output transfer, no input, skid empty: main empties (valid_o=0).
- Ordering is strictly FIFO: no loss or duplication under any valid/ready pattern.
- Output stability: while valid_o=1 && ready_i=0, decoded_o/err_o remain stable.
- Throughput: 1 transfer/cycle sustained while ready_i=1.
- Accumulator, on each edge with cke_i=1:
  - acc_clr_i=1 and output transfer: acc_o <= decoded_o. Clear happens first, then the bit is set.
  - acc_clr_i=1 only: acc_o <= 0.
  - output transfer only: acc_o <= acc_o | decoded_o.
  - err transfers contribute zero bits.
- acc_full_o is registered and updates in the same cycle as acc_o; it equals (next acc_o == all ones).
- cke_i=0 with valid_i/ready_i asserted: no transfer occurs. The upstream must treat the handshake as not taken, so valid_i && ready_o && cke_i is the effective accept.
- Reset mid-stream: buffered entries are discarded and acc_o is cleared in the same edge.

Test Plan:
- W=8, after reset, send indices 0..7 back-to-back with ready_i=1 -> decoded_o = 0x01,0x02,...,0x80 in cycles 1..8; acc_o reaches 0xFF; acc_full_o=1 in the cycle acc_o becomes 0xFF.
- W=8, send 3 then 5, ready_i=0 for 3 cycles -> decoded_o holds 0x08; ready_o=0 after the skid fills; release ready_i -> 0x08 then 0x20, no loss.
- W=6, send encoded_i=6 and 7 -> decoded_o=0x00, err_o=1 for each; acc_o unchanged.
- acc_o=0x0F; in the same cycle acc_clr_i=1 and an output transfer of 0x40 -> acc_o=0x40 next cycle, acc_full_o=0.
- Random valid_i/ready_i/cke_i toggling, 10k transfers -> output sequence equals the decoded input sequence. Scoreboard checks that ready_o never depends on same-cycle ready_i.
- Assert rst_i while both entries are full -> next cycle valid_o=0, ready_o=1, acc_o=0, decoded_o=0.
